// File: rtl/kbd_pkg.sv
// Shared key-event types, decoder/IRQ state encodings and PS/2 prefix bytes.
// Pure declarations: no logic, no latency, no flow control.
package kbd_pkg;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PULSE,
        IRQ_WAIT
    } irq_state_t;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam int         PAUSE_SKIP = 7;

endpackage

// File: rtl/kbd_event_sequencer_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the sequencer and the CPU.
// Strobes only: bytes cannot be backpressured, the CPU pops with a one-cycle read.
interface kbd_event_sequencer_if #(parameter int DEPTH = 8);
    import kbd_pkg::*;

    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   evt_rd;
    logic                   evt_valid;
    kbd_evt_t               evt_data;
    logic [$clog2(DEPTH):0] evt_count;
    logic                   intrpt;
    logic                   overflow;
    logic                   ovf_clr;

    modport slave (
        input  byte_valid, byte_data, evt_rd, ovf_clr,
        output evt_valid, evt_data, evt_count, intrpt, overflow
    );

    modport master (
        output byte_valid, byte_data, evt_rd, ovf_clr,
        input  evt_valid, evt_data, evt_count, intrpt, overflow
    );

endinterface

// File: rtl/kbd_evt_fifo.sv
// Event FIFO, first-word-fall-through; a push is written at the edge it is sampled.
// No backpressure: a push while full with no simultaneous pop is dropped and flagged.
module kbd_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   drop_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full, do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/kbd_event_sequencer.sv
// Folds PS/2 scancode bytes into {ext,rel,code} events, buffers them, one IRQ pulse each.
// Event written at the completing byte's edge; IRQ rises one edge later; full FIFO drops.
module kbd_event_sequencer
    import kbd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int INTR_CYCLES = 7,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    kbd_event_sequencer_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int PW = $clog2(INTR_CYCLES + 1);

    dec_state_t     dec_q, dec_d;
    logic [2:0]     skip_q, skip_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    irq_state_t     irq_q, irq_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           ack_q, ack_d;
    logic           ovf_q;

    logic           push, empty, drop, pop;
    kbd_evt_t       push_evt, head;

    kbd_evt_fifo #(.DEPTH(DEPTH), .WIDTH($bits(kbd_evt_t))) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_evt),
        .pop_i      (bus.evt_rd),
        .head_dat_o (head),
        .count_o    (bus.evt_count),
        .empty_o    (empty),
        .drop_o     (drop)
    );

    assign pop           = bus.evt_rd & ~empty;
    assign bus.evt_valid = ~empty;
    assign bus.evt_data  = head;
    assign bus.intrpt    = (irq_q == IRQ_PULSE);
    assign bus.overflow  = ovf_q;

    // ext/rel are implied by the decoder state, so returning to ST_IDLE clears them.
    always_comb begin
        dec_d    = dec_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        push_evt = '0;
        if (bus.byte_valid) begin
            tmo_d = '0;
            unique case (dec_q)
                ST_IDLE: begin
                    if (bus.byte_data == PFX_EXT) begin
                        dec_d = ST_EXT;
                    end else if (bus.byte_data == PFX_BRK) begin
                        dec_d = ST_BRK;
                    end else if (bus.byte_data == PFX_PAUSE) begin
                        dec_d  = ST_PAUSE;
                        skip_d = 3'(PAUSE_SKIP);
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, rel: 1'b0, code: bus.byte_data};
                    end
                end
                ST_EXT: begin
                    if (bus.byte_data == PFX_BRK) begin
                        dec_d = ST_EXT_BRK;
                    end else if (bus.byte_data != PFX_EXT) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, rel: 1'b0, code: bus.byte_data};
                        dec_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    dec_d = ST_IDLE;
                    if (bus.byte_data != PFX_BRK && bus.byte_data != PFX_EXT) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, rel: 1'b1, code: bus.byte_data};
                    end
                end
                ST_EXT_BRK: begin
                    push     = 1'b1;
                    push_evt = '{ext: 1'b1, rel: 1'b1, code: bus.byte_data};
                    dec_d    = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, rel: 1'b0, code: PFX_PAUSE};
                        dec_d    = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: dec_d = ST_IDLE;
            endcase
        end else if (dec_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                dec_d = ST_IDLE;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // A pop seen during the pulse is remembered so IRQ_WAIT lasts a single cycle.
    always_comb begin
        irq_d  = irq_q;
        pcnt_d = pcnt_q;
        ack_d  = ack_q;
        unique case (irq_q)
            IRQ_IDLE: begin
                if (!empty) begin
                    irq_d  = IRQ_PULSE;
                    pcnt_d = '0;
                    ack_d  = 1'b0;
                end
            end
            IRQ_PULSE: begin
                if (pop) ack_d = 1'b1;
                if (pcnt_q == PW'(INTR_CYCLES - 1)) irq_d  = IRQ_WAIT;
                else                                pcnt_d = pcnt_q + PW'(1);
            end
            IRQ_WAIT: begin
                if (ack_q || pop) begin
                    irq_d = IRQ_IDLE;
                    ack_d = 1'b0;
                end
            end
            default: irq_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q  <= ST_IDLE;
            skip_q <= '0;
            tmo_q  <= '0;
            irq_q  <= IRQ_IDLE;
            pcnt_q <= '0;
            ack_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dec_q  <= dec_d;
            skip_q <= skip_d;
            tmo_q  <= tmo_d;
            irq_q  <= irq_d;
            pcnt_q <= pcnt_d;
            ack_q  <= ack_d;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

endmodule
